// File: rtl/dpe_demux_if.sv
// dpe_if: AXI-Stream style bus used on every port of the DPE datapath.
// master drives data/valid and samples tready; slave does the opposite.
interface dpe_if #(
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/dpe_demux.sv
// dpe_demux: routes each packet from one dpe_if input to any subset of five
// dpe_if outputs, selected by the destination mask in tuser[4:0] of the first
// beat. Each output has a single registered stage; broadcast beats advance
// only when every selected output can take them, so the ports stay aligned.
//
// Build option: define DPE_DEMUX_DROP_EN to silently consume packets whose
// first-beat mask is zero. Without it a zero mask is steered to outp0.
module dpe_demux #(
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5
) (
  input  logic  clk,
  input  logic  rst,
  dpe_if.slave  inp,
  dpe_if.master outp0,
  dpe_if.master outp1,
  dpe_if.master outp2,
  dpe_if.master outp3,
  dpe_if.master outp4
);
  localparam int NPORTS      = 5;
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic                    sop;
  logic [NPORTS-1:0]       latched_mask;
  logic [NPORTS-1:0]       sop_mask;
  logic [NPORTS-1:0]       cur_mask;
  logic [NPORTS-1:0]       out_ready;
  logic [NPORTS-1:0]       out_valid;
  logic [NPORTS-1:0]       can_load;
  logic [NPORTS-1:0]       out_last;
  logic [TDATA_WIDTH-1:0]  out_data [NPORTS];
  logic [TKEEP_WIDTH-1:0]  out_keep [NPORTS];
  logic [TUSER_WIDTH-1:0]  out_user [NPORTS];
  logic                    accept;

  assign out_ready = {outp4.tready, outp3.tready, outp2.tready,
                      outp1.tready, outp0.tready};

  // An output register can take a new beat when it is empty or draining now.
  assign can_load = ~out_valid | out_ready;

  // Routing mask: taken from tuser on the first beat, held for the rest.
  always_comb begin
    sop_mask = inp.tuser[NPORTS-1:0];
`ifndef DPE_DEMUX_DROP_EN
    if (sop_mask == '0) begin
      sop_mask = {{(NPORTS-1){1'b0}}, 1'b1};
    end
`endif
    cur_mask = sop ? sop_mask : latched_mask;
  end

  // Unselected ports never block; a zero mask (drop build) accepts freely.
  assign inp.tready = !rst && (&(can_load | ~cur_mask));
  assign accept     = inp.tvalid && inp.tready;

  // Packet framing: track start-of-packet and remember the mask it chose.
  always_ff @(posedge clk) begin
    if (rst) begin
      sop          <= 1'b1;
      latched_mask <= '0;
    end else if (accept) begin
      sop <= inp.tlast;
      if (sop) begin
        latched_mask <= sop_mask;
      end
    end
  end

  // Per-port output registers: load on accept when selected, else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      for (int k = 0; k < NPORTS; k++) begin
        out_data[k] <= '0;
        out_keep[k] <= '0;
        out_user[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (accept && cur_mask[k]) begin
          out_valid[k] <= 1'b1;
          out_last[k]  <= inp.tlast;
          out_data[k]  <= inp.tdata;
          out_keep[k]  <= inp.tkeep;
          out_user[k]  <= inp.tuser;
        end else if (out_valid[k] && out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign outp0.tvalid = out_valid[0];
  assign outp0.tlast  = out_last[0];
  assign outp0.tdata  = out_data[0];
  assign outp0.tkeep  = out_keep[0];
  assign outp0.tuser  = out_user[0];

  assign outp1.tvalid = out_valid[1];
  assign outp1.tlast  = out_last[1];
  assign outp1.tdata  = out_data[1];
  assign outp1.tkeep  = out_keep[1];
  assign outp1.tuser  = out_user[1];

  assign outp2.tvalid = out_valid[2];
  assign outp2.tlast  = out_last[2];
  assign outp2.tdata  = out_data[2];
  assign outp2.tkeep  = out_keep[2];
  assign outp2.tuser  = out_user[2];

  assign outp3.tvalid = out_valid[3];
  assign outp3.tlast  = out_last[3];
  assign outp3.tdata  = out_data[3];
  assign outp3.tkeep  = out_keep[3];
  assign outp3.tuser  = out_user[3];

  assign outp4.tvalid = out_valid[4];
  assign outp4.tlast  = out_last[4];
  assign outp4.tdata  = out_data[4];
  assign outp4.tkeep  = out_keep[4];
  assign outp4.tuser  = out_user[4];
endmodule

// File: tb/tb_dpe_demux.sv
// tb_dpe_demux: scoreboard bench for dpe_demux. Accepted input beats are
// pushed to per-port expected queues; a negedge monitor records every
// output handshake and also models inp.tready and stall stability.
// Honours DPE_DEMUX_DROP_EN the same way the design does.
module tb_dpe_demux;
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic [4:0]   user;
    logic         last;
    logic [31:0]  cyc;
  } beat_t;

  logic clk;
  logic rst;

  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) di ();
  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) o0 ();
  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) o1 ();
  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) o2 ();
  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) o3 ();
  dpe_if #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) o4 ();

  dpe_demux #(.TDATA_WIDTH(128), .TUSER_WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .inp   (di),
    .outp0 (o0),
    .outp1 (o1),
    .outp2 (o2),
    .outp3 (o3),
    .outp4 (o4)
  );

  int          total;
  int          bad;
  int          cyc;
  int          pidx;
  int          rdy_err;
  int          stab_err;
  logic        ready_mode;
  logic [4:0]  manual_ready;
  logic [14:0] pat;
  logic [4:0]  cur_mask_tb;

  logic [4:0]   ov;
  logic [4:0]   orr;
  logic [4:0]   ol;
  logic [127:0] od [5];
  logic [15:0]  okp [5];
  logic [4:0]   ou [5];

  beat_t exp_q [5][$];
  beat_t obs_q [5][$];

  assign ov = {o4.tvalid, o3.tvalid, o2.tvalid, o1.tvalid, o0.tvalid};
  assign ol = {o4.tlast, o3.tlast, o2.tlast, o1.tlast, o0.tlast};
  assign od[0] = o0.tdata;  assign od[1] = o1.tdata;  assign od[2] = o2.tdata;
  assign od[3] = o3.tdata;  assign od[4] = o4.tdata;
  assign okp[0] = o0.tkeep; assign okp[1] = o1.tkeep; assign okp[2] = o2.tkeep;
  assign okp[3] = o3.tkeep; assign okp[4] = o4.tkeep;
  assign ou[0] = o0.tuser;  assign ou[1] = o1.tuser;  assign ou[2] = o2.tuser;
  assign ou[3] = o3.tuser;  assign ou[4] = o4.tuser;

  assign orr[0] = ready_mode ? pat[(pidx + 0) % 15]  : manual_ready[0];
  assign orr[1] = ready_mode ? pat[(pidx + 3) % 15]  : manual_ready[1];
  assign orr[2] = ready_mode ? pat[(pidx + 6) % 15]  : manual_ready[2];
  assign orr[3] = ready_mode ? pat[(pidx + 9) % 15]  : manual_ready[3];
  assign orr[4] = ready_mode ? pat[(pidx + 12) % 15] : manual_ready[4];
  assign o0.tready = orr[0];
  assign o1.tready = orr[1];
  assign o2.tready = orr[2];
  assign o3.tready = orr[3];
  assign o4.tready = orr[4];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and ready-pattern index, stepped just after each edge.
  initial begin
    cyc  = 0;
    pidx = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      pidx = (pidx + 1) % 15;
    end
  end

  // Output monitor: records handshakes, checks stall stability and tready.
  initial begin
    logic [4:0]   prev_stall;
    logic [127:0] prev_data [5];
    logic         exp_rdy;
    beat_t        ob;
    prev_stall = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = '0;
      end else begin
        exp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
          if (prev_stall[k] && (ov[k] !== 1'b1 || od[k] !== prev_data[k]))
            stab_err = stab_err + 1;
          if (ov[k] === 1'b1 && orr[k] === 1'b1) begin
            ob.data = od[k];
            ob.keep = okp[k];
            ob.user = ou[k];
            ob.last = ol[k];
            ob.cyc  = cyc;
            obs_q[k].push_back(ob);
          end
          if (cur_mask_tb[k] && ov[k] === 1'b1 && orr[k] === 1'b0)
            exp_rdy = 1'b0;
          prev_stall[k] = (ov[k] === 1'b1) && (orr[k] === 1'b0);
          prev_data[k]  = od[k];
        end
        if (di.tvalid === 1'b1 && di.tready !== exp_rdy)
          rdy_err = rdy_err + 1;
      end
    end
  end

  // Scoreboard push for every port the accepted beat is routed to.
  function automatic void push_exp(input logic [4:0] m, input beat_t b);
    for (int k = 0; k < 5; k++)
      if (m[k]) exp_q[k].push_back(b);
  endfunction

  // Drive one packet beat by beat, waiting (bounded) for each acceptance.
  task automatic send_packet(input logic [4:0] mask, input int n,
                             input logic [7:0] base, input bit end_pkt,
                             output int max_wait);
    beat_t      b;
    logic [4:0] eff;
    bit         acc;
    eff = mask;
`ifndef DPE_DEMUX_DROP_EN
    if (mask == 5'b0) eff = 5'b00001;
`endif
    cur_mask_tb = eff;
    max_wait    = 0;
    for (int i = 0; i < n; i++) begin
      b.data      = {$urandom, $urandom, $urandom, $urandom};
      b.data[7:0] = base + 8'(i);
      b.keep      = 16'($urandom);
      b.user      = (i == 0) ? mask : 5'($urandom);
      b.last      = end_pkt && (i == n - 1);
      b.cyc       = 0;
      di.tdata  = b.data;
      di.tkeep  = b.keep;
      di.tuser  = b.user;
      di.tlast  = b.last;
      di.tvalid = 1'b1;
      acc = 1'b0;
      for (int w = 0; w < 500 && !acc; w++) begin
        @(negedge clk);
        if (di.tready === 1'b1) begin
          acc   = 1'b1;
          b.cyc = cyc;
          push_exp(eff, b);
          if (w > max_wait) max_wait = w;
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        total = total + 1;
        bad   = bad + 1;
        $display("[TB] FAIL send_packet accept timeout: beat %0d got tready=0 want 1", i);
      end
    end
    di.tvalid = 1'b0;
  endtask

  // Hold all outputs ready until every expected beat has been observed.
  task automatic wait_drain();
    bit done;
    ready_mode   = 1'b0;
    manual_ready = 5'b11111;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      done = (ov == 5'b0);
      for (int k = 0; k < 5; k++)
        if (obs_q[k].size() < exp_q[k].size()) done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic zero_ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total = total + 1;
    if (di.tready !== 1'b0) begin
      bad = bad + 1;
      $display("[TB] FAIL reset tready: got %b want 0", di.tready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total = total + 1;
    if (ov !== 5'b0) begin
      bad = bad + 1;
      $display("[TB] FAIL reset tvalid: got %b want 00000", ov);
    end
    zero_ok = 1'b1;
    for (int k = 0; k < 5; k++)
      if (od[k] !== 128'b0 || okp[k] !== 16'b0 || ou[k] !== 5'b0 || ol[k] !== 1'b0)
        zero_ok = 1'b0;
    total = total + 1;
    if (zero_ok !== 1'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL reset payload: got nonzero want all zero");
    end
    total = total + 1;
    if (di.tready !== 1'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL idle tready: got %b want 1", di.tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int    w;
    beat_t e, o;
    send_packet(5'b00001, 6, 8'h01, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL single port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL single port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
        total = total + 1;
        if (o.cyc !== e.cyc + 1) begin
          bad = bad + 1;
          $display("[TB] FAIL single port%0d latency: got %0d want %0d", k, o.cyc - e.cyc, 1);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
  endtask

  task automatic test_back_to_back();
    int    w;
    beat_t e, o;
    send_packet(5'b00010, 4, 8'h10, 1'b1, w);
    send_packet(5'b00100, 5, 8'h18, 1'b1, w);
    send_packet(5'b01000, 4, 8'h20, 1'b1, w);
    send_packet(5'b10000, 4, 8'h28, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL b2b port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL b2b port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
  endtask

  task automatic test_broadcast();
    int    w;
    beat_t e, o;
    send_packet(5'b11111, 5, 8'h33, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL bcast port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL bcast port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
  endtask

  task automatic test_toggle();
    int    w;
    beat_t e, o;
    rdy_err    = 0;
    stab_err   = 0;
    ready_mode = 1'b1;
    send_packet(5'b00010, 4, 8'h80, 1'b1, w);
    send_packet(5'b00100, 5, 8'h88, 1'b1, w);
    send_packet(5'b01000, 4, 8'h90, 1'b1, w);
    send_packet(5'b10000, 4, 8'h98, 1'b1, w);
    send_packet(5'b11111, 5, 8'hA0, 1'b1, w);
    send_packet(5'b10101, 6, 8'hA8, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL toggle port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL toggle port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
    total = total + 1;
    if (rdy_err != 0) begin
      bad = bad + 1;
      $display("[TB] FAIL toggle tready model: got %0d disagreements want 0", rdy_err);
    end
    total = total + 1;
    if (stab_err != 0) begin
      bad = bad + 1;
      $display("[TB] FAIL toggle stall stability: got %0d changes want 0", stab_err);
    end
  endtask

  task automatic test_stall_port3();
    beat_t b0, b1, e, o;
    rdy_err      = 0;
    stab_err     = 0;
    ready_mode   = 1'b0;
    manual_ready = 5'b10111;
    cur_mask_tb  = 5'b11111;
    b0.data = {$urandom, $urandom, $urandom, $urandom};
    b0.data[7:0] = 8'h40;
    b0.keep = 16'($urandom); b0.user = 5'b11111; b0.last = 1'b0; b0.cyc = 0;
    di.tdata = b0.data; di.tkeep = b0.keep; di.tuser = b0.user; di.tlast = b0.last;
    di.tvalid = 1'b1;
    @(negedge clk);
    total = total + 1;
    if (di.tready !== 1'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL stall first beat tready: got %b want 1", di.tready);
    end
    push_exp(5'b11111, b0);
    @(posedge clk); #1;
    b1.data = {$urandom, $urandom, $urandom, $urandom};
    b1.data[7:0] = 8'h41;
    b1.keep = 16'($urandom); b1.user = 5'($urandom); b1.last = 1'b1; b1.cyc = 0;
    di.tdata = b1.data; di.tkeep = b1.keep; di.tuser = b1.user; di.tlast = b1.last;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total = total + 1;
      if (di.tready !== 1'b0) begin
        bad = bad + 1;
        $display("[TB] FAIL stall tready cycle %0d: got %b want 0", c, di.tready);
      end
      total = total + 1;
      if (ov[3] !== 1'b1 || od[3] !== b0.data) begin
        bad = bad + 1;
        $display("[TB] FAIL stall port3 hold cycle %0d: got v=%b d=%h want v=1 d=%h", c, ov[3], od[3][7:0], b0.data[7:0]);
      end
      if (c > 0) begin
        total = total + 1;
        if ((ov & 5'b10111) !== 5'b0) begin
          bad = bad + 1;
          $display("[TB] FAIL stall others advanced cycle %0d: got %b want 00000", c, ov & 5'b10111);
        end
      end
      @(posedge clk); #1;
    end
    manual_ready = 5'b11111;
    @(negedge clk);
    total = total + 1;
    if (di.tready !== 1'b1) begin
      bad = bad + 1;
      $display("[TB] FAIL stall release tready: got %b want 1", di.tready);
    end
    push_exp(5'b11111, b1);
    @(posedge clk); #1;
    di.tvalid = 1'b0;
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL stall port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL stall port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
    total = total + 1;
    if (rdy_err != 0 || stab_err != 0) begin
      bad = bad + 1;
      $display("[TB] FAIL stall monitors: got rdy=%0d stab=%0d want 0 0", rdy_err, stab_err);
    end
  endtask

  task automatic test_zero_mask();
    int    w;
    beat_t e, o;
    send_packet(5'b00000, 3, 8'h70, 1'b1, w);
    total = total + 1;
    if (w != 0) begin
      bad = bad + 1;
      $display("[TB] FAIL zero mask accept stalls: got %0d want 0", w);
    end
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL zero port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL zero port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
  endtask

  task automatic test_reset_mid();
    int    w;
    beat_t e, o;
    ready_mode   = 1'b0;
    manual_ready = 5'b11011;
    send_packet(5'b00100, 1, 8'h50, 1'b0, w);
    di.tdata  = {$urandom, $urandom, $urandom, $urandom};
    di.tkeep  = 16'($urandom);
    di.tuser  = 5'b00100;
    di.tlast  = 1'b0;
    di.tvalid = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    total = total + 1;
    if (di.tready !== 1'b0) begin
      bad = bad + 1;
      $display("[TB] FAIL mid reset tready: got %b want 0", di.tready);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    di.tvalid    = 1'b0;
    manual_ready = 5'b11111;
    total = total + 1;
    if (ov !== 5'b0) begin
      bad = bad + 1;
      $display("[TB] FAIL mid reset tvalid: got %b want 00000", ov);
    end
    total = total + 1;
    if (od[2] !== 128'b0 || ou[2] !== 5'b0 || ol[2] !== 1'b0) begin
      bad = bad + 1;
      $display("[TB] FAIL mid reset port2 payload: got d=%h u=%b want 0", od[2][7:0], ou[2]);
    end
    for (int k = 0; k < 5; k++) begin
      exp_q[k].delete();
      obs_q[k].delete();
    end
    send_packet(5'b01000, 3, 8'h60, 1'b1, w);
    wait_drain();
    for (int k = 0; k < 5; k++) begin
      total = total + 1;
      if (obs_q[k].size() != exp_q[k].size()) begin
        bad = bad + 1;
        $display("[TB] FAIL after reset port%0d count: got %0d want %0d", k, obs_q[k].size(), exp_q[k].size());
      end
      while (exp_q[k].size() > 0 && obs_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        o = obs_q[k].pop_front();
        total = total + 1;
        if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
          bad = bad + 1;
          $display("[TB] FAIL after reset port%0d beat: got d=%h l=%b want d=%h l=%b", k, o.data[7:0], o.last, e.data[7:0], e.last);
        end
      end
      exp_q[k].delete();
      obs_q[k].delete();
    end
  endtask

  // Test sequence.
  initial begin
    total        = 0;
    bad          = 0;
    rdy_err      = 0;
    stab_err     = 0;
    ready_mode   = 1'b0;
    manual_ready = 5'b11111;
    pat          = 15'b000111101111111;
    cur_mask_tb  = 5'b0;
    rst          = 1'b1;
    di.tvalid    = 1'b0;
    di.tdata     = '0;
    di.tkeep     = '0;
    di.tuser     = '0;
    di.tlast     = 1'b0;
    $display("[TB] starting dpe_demux bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_broadcast();
    test_toggle();
    test_stall_port3();
    test_zero_mask();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dpe_demux.md
Name: dpe_demux

Overview:
- AXI-Stream style packet demultiplexer in the DPE (data-plane engine) datapath.
- Takes one dpe_if input stream and routes each packet to one or more of five dpe_if output streams.
- Routing is set by the destination mask carried in tuser on the first beat of the packet.
- Mask bit k selects outp k; a multi-hot mask broadcasts the packet to every selected port.

Parameters:
- TDATA_WIDTH, 128, width of tdata on all interfaces; tkeep width is TDATA_WIDTH/8.
- TUSER_WIDTH, 5, width of tuser; must be >= 5; bits [4:0] are the destination mask.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset; synchronous, active-high.
- inp  dpe_if sink  tdata TDATA_WIDTH, tkeep TDATA_WIDTH/8, tuser TUSER_WIDTH, tlast 1, tvalid 1 (in); tready 1 (out).
- outp0..outp4  dpe_if source  same signal set; tdata/tkeep/tuser/tlast/tvalid out, tready in.

Behaviour:
- Handshake: a beat transfers when tvalid && tready at a posedge clk. Output tvalid never depends combinationally on output tready.
- Each output k has a one-beat output register holding data/keep/user/last/valid. Latency from input acceptance to output valid is 1 clock.
- can_load_k = !out_valid_k || outp_k.tready.
- Active mask:
  - On the first beat of a packet (sop flag = 1), mask = inp.tuser[4:0].
  - On later beats, mask = the value latched at SOP. tuser on later beats is ignored for routing.
- inp.tready = AND over k of (can_load_k || !mask[k]). inp.tready is 0 while rst = 1.
- On input acceptance, each output k with mask[k] = 1 loads inp.tdata/tkeep/tuser/tlast and sets out_valid_k = 1.
- Any output k whose register drains (out_valid_k && tready) without being loaded clears out_valid_k.
- Load and drain in the same cycle on one port: the new beat replaces the old one; valid stays 1.
- tuser is forwarded unmodified, as the full original value.
- sop flag:
  - Set to 1 at reset.
  - Cleared when a non-last beat is accepted.
  - Set to 1 when a tlast beat is accepted.
  - A single-beat packet (tlast on its first beat) leaves sop = 1.
- Broadcast: a beat advances only when all selected ports can load. Ports stay beat-aligned; there is no per-port buffering beyond one register.
- Back-to-back packets with different masks need no idle cycle. Packet N+1 beats may load port j while port k still drains packet N.
- Reset (also when asserted mid-packet):
  - All out tvalid = 0; out tdata/tkeep/tuser/tlast = 0.
  - sop = 1; latched mask = 0.
  - In-flight beats are discarded; no partial-packet completion is attempted.
- Zero mask: handling is set by the optional feature below.

Optional Feature:
- Macro: DPE_DEMUX_DROP_EN.
- Defined: a packet whose SOP mask is 0 is consumed and discarded. inp.tready = 1 for every beat of it; no output asserts tvalid.
- Not defined: a zero SOP mask is replaced by 5'b00001, so the packet is routed to outp0.

Test Plan:
- Reset release, all outputs ready, 6-beat packet with tuser=5'b00001, tdata[7:0]=01..06 -> outp0 delivers 6 beats in order, tlast on the 6th (data 06), one cycle after each input beat; other ports stay idle.
- Packets with tuser 00010 (4 beats), 00100 (5 beats), 01000 (4 beats), 10000 (4 beats), sent back-to-back -> ports 1/2/3/4 report 4/5/4/4 words respectively, with tlast on the correct beat and data order preserved.
- Broadcast packet tuser=5'b11111, 5 beats, data 33..37 -> all five ports each deliver 5 beats with identical data and tlast on beat 5.
- Output tready toggling pattern (1 for 7 cycles, 0 for 1, 1 for 4, 0 for 3, ...) during the above sequence:
  - inp.tready drops whenever a selected port is full and not ready.
  - No beat is lost or duplicated; output tvalid/tdata stay stable while stalled.
- Broadcast with only outp3.tready=0 -> inp.tready=0; no port advances its next beat until outp3 accepts.
- Zero mask packet, 3 beats:
  - With DPE_DEMUX_DROP_EN -> accepted every cycle, no output activity.
  - Without it -> the 3 beats appear on outp0.
- rst asserted mid-packet -> all output tvalid 0 the next cycle; a following packet routes by its own SOP tuser.
